// File: rtl/apb4_master_pkg.sv
// apb4_master_pkg: shared FSM state type and APB4 phase encodings for the
// apb4_master slice (apb4_master, apb4_master_timer, apb4_master_if users).
package apb4_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Bus phase encoded as {psel, penable}.
    localparam logic [1:0] PHASE_IDLE   = 2'b00;
    localparam logic [1:0] PHASE_SETUP  = 2'b10;
    localparam logic [1:0] PHASE_ACCESS = 2'b11;

endpackage

// File: rtl/apb4_master_if.sv
// apb4_master_if: APB4 requester/completer bus bundle. The master modport is
// the requester drive, the slave modport is the completer response.
interface apb4_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslerr;

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslerr
    );

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslerr
    );
endinterface

// File: rtl/apb4_master_timer.sv
// apb4_master_timer: counts consecutive ACCESS wait cycles (pready=0) and
// flags the cycle on which the TIMEOUT_CYCLES-th wait cycle occurs.
// Only instantiated when APB4_MASTER_TIMEOUT_EN is defined.
module apb4_master_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = count_en && (cnt_q == LAST);

    // Wait-cycle counter: cleared on each new request, saturates at LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/apb4_master.sv
// apb4_master: single-outstanding APB4 requester. A valid/ready request is
// registered, driven through SETUP and ACCESS, and the completer response is
// held in RESP until consumed. Optional wait-state timeout is enabled by
// defining APB4_MASTER_TIMEOUT_EN.
module apb4_master
    import apb4_master_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [2:0]  PROT           = 3'b000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    apb4_master_if.master           apb
);
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("apb4_master: DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb4_master: TIMEOUT_CYCLES must be >= 2");
    end

    state_t                  state_q;
    logic [1:0]              phase_q;
    logic                    req_ready_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH/8-1:0] pstrb_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    accept;

    assign accept = req_valid_i && req_ready_q;

`ifdef APB4_MASTER_TIMEOUT_EN
    logic wait_cycle;
    logic timeout_hit;

    assign wait_cycle = (state_q == ST_ACCESS) && !apb.pready;

    apb4_master_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (hclk),
        .rst_n    (hresetn),
        .clear    (accept),
        .count_en (wait_cycle),
        .expired  (timeout_hit)
    );
`endif

    // Transfer FSM with all bus and response outputs registered.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            phase_q     <= PHASE_IDLE;
            req_ready_q <= 1'b1;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_SETUP;
                        phase_q     <= PHASE_SETUP;
                        req_ready_q <= 1'b0;
                        paddr_q     <= req_addr_i;
                        pwrite_q    <= req_write_i;
                        // Reads present a quiet write bus.
                        pwdata_q    <= req_write_i ? req_wdata_i : '0;
                        pstrb_q     <= req_write_i ? req_strb_i : '0;
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_ACCESS;
                    phase_q <= PHASE_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb.pready) begin
                        state_q     <= ST_RESP;
                        phase_q     <= PHASE_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : apb.prdata;
                        rsp_err_q   <= apb.pslerr;
                    end
`ifdef APB4_MASTER_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state_q     <= ST_RESP;
                        phase_q     <= PHASE_IDLE;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    phase_q     <= PHASE_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    assign apb.psel    = phase_q[1];
    assign apb.penable = phase_q[0];
    assign apb.paddr   = paddr_q;
    assign apb.pprot   = PROT;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pstrb   = pstrb_q;
endmodule
